decode_issue_unit: RTL



---
 rtl/decode_issue_unit.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_issue_unit.sv
// Decode/issue stage with a one-entry skid register between the fetcher and
// the ROB / reservation station / load-store buffer. Operands are resolved
// at capture time from the register file, the ROB or the CDB channels, and
// pending operands keep snooping the CDB until the instruction issues.
module decode_issue_unit #(
    parameter int ROB_POS_WID = 4,
    parameter int NUM_CDB     = 2,
    parameter int DATA_WID    = 32,
    parameter int ADDR_WID    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          rollback,
    input  logic                          inst_valid,
    input  logic [31:0]                   inst,
    input  logic [ADDR_WID-1:0]           inst_pc,
    input  logic                          inst_pred_jump,
    output logic                          inst_ack,
    output logic [4:0]                    reg_rs1,
    output logic [4:0]                    reg_rs2,
    input  logic [DATA_WID-1:0]           reg_rs1_val,
    input  logic [DATA_WID-1:0]           reg_rs2_val,
    input  logic [ROB_POS_WID:0]          reg_rs1_tag,
    input  logic [ROB_POS_WID:0]          reg_rs2_tag,
    output logic [ROB_POS_WID-1:0]        rob_rs1_pos,
    output logic [ROB_POS_WID-1:0]        rob_rs2_pos,
    input  logic                          rob_rs1_ready,
    input  logic                          rob_rs2_ready,
    input  logic [DATA_WID-1:0]           rob_rs1_val,
    input  logic [DATA_WID-1:0]           rob_rs2_val,
    input  logic                          rob_nxt_full,
    input  logic                          rs_nxt_full,
    input  logic                          lsb_nxt_full,
    input  logic [ROB_POS_WID-1:0]        nxt_rob_pos,
    input  logic [NUM_CDB-1:0]            cdb_valid,
    input  logic [NUM_CDB*ROB_POS_WID-1:0] cdb_pos,
    input  logic [NUM_CDB*DATA_WID-1:0]   cdb_val,
    output logic                          issue,
    output logic                          rs_en,
    output logic                          lsb_en,
    output logic [ROB_POS_WID-1:0]        rob_pos,
    output logic [6:0]                    opcode,
    output logic [2:0]                    funct3,
    output logic                          funct7,
    output logic [4:0]                    rd,
    output logic [ADDR_WID-1:0]           pc,
    output logic                          pred_jump,
    output logic                          is_ready,
    output logic [DATA_WID-1:0]           imm,
    output logic [DATA_WID-1:0]           rs1_val,
    output logic [DATA_WID-1:0]           rs2_val,
    output logic [ROB_POS_WID:0]          rs1_tag,
    output logic [ROB_POS_WID:0]          rs2_tag
);

    localparam int TAG_WID = ROB_POS_WID + 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Skid register contents
    logic [6:0]          r_h_opcode;
    logic [2:0]          r_h_funct3;
    logic                r_h_funct7;
    logic [4:0]          r_h_rd;
    logic [ADDR_WID-1:0] r_h_pc;
    logic                r_h_pred_jump;
    logic                r_h_is_ready;
    logic                r_h_rs;
    logic                r_h_lsb;
    logic                r_h_ls;
    logic [DATA_WID-1:0] r_h_imm;
    logic [DATA_WID-1:0] r_h_rs1_val;
    logic [DATA_WID-1:0] r_h_rs2_val;
    logic [TAG_WID-1:0]  r_h_rs1_tag;
    logic [TAG_WID-1:0]  r_h_rs2_tag;

    // Issue-side output registers
    logic                r_issue;
    logic                r_rs_en;
    logic                r_lsb_en;
    logic [ROB_POS_WID-1:0] r_rob_pos;
    logic [6:0]          r_opcode;
    logic [2:0]          r_funct3;
    logic                r_funct7;
    logic [4:0]          r_rd;
    logic [ADDR_WID-1:0] r_pc;
    logic                r_pred_jump;
    logic                r_is_ready;
    logic [DATA_WID-1:0] r_imm;
    logic [DATA_WID-1:0] r_rs1_val;
    logic [DATA_WID-1:0] r_rs2_val;
    logic [TAG_WID-1:0]  r_rs1_tag;
    logic [TAG_WID-1:0]  r_rs2_tag;

    // Decoder outputs for the incoming instruction
    logic [6:0]          w_op;
    logic [4:0]          w_rs1_idx;
    logic [4:0]          w_rs2_idx;
    logic                w_d_rs;
    logic                w_d_lsb;
    logic                w_d_ls;
    logic                w_d_ready;
    logic                w_d_mask1;
    logic                w_d_mask2;
    logic [31:0]         w_imm32;
    logic [DATA_WID-1:0] w_d_imm;

    // CDB unpacking and match vectors
    logic [ROB_POS_WID-1:0] w_cdb_pos [NUM_CDB];
    logic [DATA_WID-1:0]    w_cdb_val [NUM_CDB];
    logic [NUM_CDB-1:0]     w_hit_c1;
    logic [NUM_CDB-1:0]     w_hit_c2;
    logic [NUM_CDB-1:0]     w_hit_h1;
    logic [NUM_CDB-1:0]     w_hit_h2;
    logic [DATA_WID-1:0]    w_c1_cdb;
    logic [DATA_WID-1:0]    w_c2_cdb;
    logic [DATA_WID-1:0]    w_h1_cdb;
    logic [DATA_WID-1:0]    w_h2_cdb;

    // Resolved operands at capture and snooped operands while held
    logic [DATA_WID-1:0] w_c1_val;
    logic [DATA_WID-1:0] w_c2_val;
    logic [TAG_WID-1:0]  w_c1_tag;
    logic [TAG_WID-1:0]  w_c2_tag;
    logic [DATA_WID-1:0] w_s1_val;
    logic [DATA_WID-1:0] w_s2_val;
    logic [TAG_WID-1:0]  w_s1_tag;
    logic [TAG_WID-1:0]  w_s2_tag;

    logic w_target_full;
    logic w_fire;

    assign w_op      = inst[6:0];
    assign w_rs1_idx = inst[19:15];
    assign w_rs2_idx = inst[24:20];

    assign reg_rs1     = w_rs1_idx;
    assign reg_rs2     = w_rs2_idx;
    assign rob_rs1_pos = reg_rs1_tag[ROB_POS_WID-1:0];
    assign rob_rs2_pos = reg_rs2_tag[ROB_POS_WID-1:0];

    // Loads and stores wait on the LSB, everything else (nops included) on the RS
    assign w_target_full = r_h_ls ? lsb_nxt_full : rs_nxt_full;
    assign w_fire        = (r_state == ST_HELD) && !w_target_full && !rob_nxt_full;
    assign inst_ack      = rdy && !rst && !rollback && inst_valid &&
                           ((r_state == ST_EMPTY) || w_fire);

    // Per-channel tag comparators for both capture-time and held operands
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CDB; gi++) begin : g_cdb
            assign w_cdb_pos[gi] = cdb_pos[gi*ROB_POS_WID +: ROB_POS_WID];
            assign w_cdb_val[gi] = cdb_val[gi*DATA_WID +: DATA_WID];
            assign w_hit_c1[gi]  = cdb_valid[gi] &&
                                   (w_cdb_pos[gi] == reg_rs1_tag[ROB_POS_WID-1:0]);
            assign w_hit_c2[gi]  = cdb_valid[gi] &&
                                   (w_cdb_pos[gi] == reg_rs2_tag[ROB_POS_WID-1:0]);
            assign w_hit_h1[gi]  = cdb_valid[gi] && r_h_rs1_tag[TAG_WID-1] &&
                                   (w_cdb_pos[gi] == r_h_rs1_tag[ROB_POS_WID-1:0]);
            assign w_hit_h2[gi]  = cdb_valid[gi] && r_h_rs2_tag[TAG_WID-1] &&
                                   (w_cdb_pos[gi] == r_h_rs2_tag[ROB_POS_WID-1:0]);
        end
    endgenerate

    // Priority select of CDB data: scanning downward lets the lowest channel win
    always_comb begin
        w_c1_cdb = '0;
        w_c2_cdb = '0;
        w_h1_cdb = '0;
        w_h2_cdb = '0;
        for (int i = NUM_CDB - 1; i >= 0; i--) begin
            if (w_hit_c1[i]) w_c1_cdb = w_cdb_val[i];
            if (w_hit_c2[i]) w_c2_cdb = w_cdb_val[i];
            if (w_hit_h1[i]) w_h1_cdb = w_cdb_val[i];
            if (w_hit_h2[i]) w_h2_cdb = w_cdb_val[i];
        end
    end

    // Opcode decode: routing, readiness, source masking and immediate format
    always_comb begin
        w_d_rs    = 1'b0;
        w_d_lsb   = 1'b0;
        w_d_ls    = 1'b0;
        w_d_ready = 1'b0;
        w_d_mask1 = 1'b0;
        w_d_mask2 = 1'b0;
        w_imm32   = '0;
        case (w_op)
            OP_LOAD: begin
                w_d_lsb   = 1'b1;
                w_d_ls    = 1'b1;
                w_d_mask2 = 1'b1;
                w_imm32   = {{20{inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                w_d_lsb   = 1'b1;
                w_d_ls    = 1'b1;
                w_d_ready = 1'b1;
                w_imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_OPIMM, OP_JALR: begin
                w_d_rs    = 1'b1;
                w_d_mask2 = 1'b1;
                w_imm32   = {{20{inst[31]}}, inst[31:20]};
            end
            OP_OP: begin
                w_d_rs    = 1'b1;
            end
            OP_BRANCH: begin
                w_d_rs    = 1'b1;
                w_imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                             inst[11:8], 1'b0};
            end
            OP_JAL: begin
                w_d_rs    = 1'b1;
                w_d_mask1 = 1'b1;
                w_d_mask2 = 1'b1;
                w_imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                             inst[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                w_d_rs    = 1'b1;
                w_d_mask1 = 1'b1;
                w_d_mask2 = 1'b1;
                w_imm32   = {inst[31:12], 12'b0};
            end
            default: begin
                // Unrecognised opcodes retire through the ROB as nops
                w_d_ready = 1'b1;
                w_d_mask1 = 1'b1;
                w_d_mask2 = 1'b1;
            end
        endcase
    end

    assign w_d_imm = DATA_WID'($signed(w_imm32));

    // Capture-time operand resolution: x0/masked, regfile, ROB, CDB, else pending
    always_comb begin
        w_c1_val = '0;
        w_c1_tag = '0;
        w_c2_val = '0;
        w_c2_tag = '0;
        if (w_d_mask1 || (w_rs1_idx == 5'd0)) begin
            w_c1_val = '0;
        end else if (!reg_rs1_tag[TAG_WID-1]) begin
            w_c1_val = reg_rs1_val;
        end else if (rob_rs1_ready) begin
            w_c1_val = rob_rs1_val;
        end else if (|w_hit_c1) begin
            w_c1_val = w_c1_cdb;
        end else begin
            w_c1_tag = reg_rs1_tag;
        end
        if (w_d_mask2 || (w_rs2_idx == 5'd0)) begin
            w_c2_val = '0;
        end else if (!reg_rs2_tag[TAG_WID-1]) begin
            w_c2_val = reg_rs2_val;
        end else if (rob_rs2_ready) begin
            w_c2_val = rob_rs2_val;
        end else if (|w_hit_c2) begin
            w_c2_val = w_c2_cdb;
        end else begin
            w_c2_tag = reg_rs2_tag;
        end
    end

    // Held operands after this cycle's CDB snoop
    always_comb begin
        w_s1_val = (|w_hit_h1) ? w_h1_cdb : r_h_rs1_val;
        w_s1_tag = (|w_hit_h1) ? '0       : r_h_rs1_tag;
        w_s2_val = (|w_hit_h2) ? w_h2_cdb : r_h_rs2_val;
        w_s2_tag = (|w_hit_h2) ? '0       : r_h_rs2_tag;
    end

    // Next state: rollback beats ack, ack beats a plain fire
    always_comb begin
        w_state_next = r_state;
        if (rdy) begin
            if (rollback) begin
                w_state_next = ST_EMPTY;
            end else if (inst_ack) begin
                w_state_next = ST_HELD;
            end else if (w_fire) begin
                w_state_next = ST_EMPTY;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Skid register: capture on ack, otherwise keep snooping while held
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_opcode    <= '0;
            r_h_funct3    <= '0;
            r_h_funct7    <= 1'b0;
            r_h_rd        <= '0;
            r_h_pc        <= '0;
            r_h_pred_jump <= 1'b0;
            r_h_is_ready  <= 1'b0;
            r_h_rs        <= 1'b0;
            r_h_lsb       <= 1'b0;
            r_h_ls        <= 1'b0;
            r_h_imm       <= '0;
            r_h_rs1_val   <= '0;
            r_h_rs2_val   <= '0;
            r_h_rs1_tag   <= '0;
            r_h_rs2_tag   <= '0;
        end else if (rdy && !rollback) begin
            if (inst_ack) begin
                r_h_opcode    <= w_op;
                r_h_funct3    <= inst[14:12];
                r_h_funct7    <= inst[30];
                r_h_rd        <= inst[11:7];
                r_h_pc        <= inst_pc;
                r_h_pred_jump <= inst_pred_jump;
                r_h_is_ready  <= w_d_ready;
                r_h_rs        <= w_d_rs;
                r_h_lsb       <= w_d_lsb;
                r_h_ls        <= w_d_ls;
                r_h_imm       <= w_d_imm;
                r_h_rs1_val   <= w_c1_val;
                r_h_rs2_val   <= w_c2_val;
                r_h_rs1_tag   <= w_c1_tag;
                r_h_rs2_tag   <= w_c2_tag;
            end else if (r_state == ST_HELD) begin
                r_h_rs1_val   <= w_s1_val;
                r_h_rs2_val   <= w_s2_val;
                r_h_rs1_tag   <= w_s1_tag;
                r_h_rs2_tag   <= w_s2_tag;
            end
        end
    end

    // Issue registers: pulse on fire, fields carry the snooped held operands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue     <= 1'b0;
            r_rs_en     <= 1'b0;
            r_lsb_en    <= 1'b0;
            r_rob_pos   <= '0;
            r_opcode    <= '0;
            r_funct3    <= '0;
            r_funct7    <= 1'b0;
            r_rd        <= '0;
            r_pc        <= '0;
            r_pred_jump <= 1'b0;
            r_is_ready  <= 1'b0;
            r_imm       <= '0;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
            r_rs1_tag   <= '0;
            r_rs2_tag   <= '0;
        end else if (!rdy || rollback) begin
            r_issue     <= 1'b0;
            r_rs_en     <= 1'b0;
            r_lsb_en    <= 1'b0;
        end else begin
            r_issue     <= w_fire;
            r_rs_en     <= w_fire && r_h_rs;
            r_lsb_en    <= w_fire && r_h_lsb;
            if (w_fire) begin
                r_rob_pos   <= nxt_rob_pos;
                r_opcode    <= r_h_opcode;
                r_funct3    <= r_h_funct3;
                r_funct7    <= r_h_funct7;
                r_rd        <= r_h_rd;
                r_pc        <= r_h_pc;
                r_pred_jump <= r_h_pred_jump;
                r_is_ready  <= r_h_is_ready;
                r_imm       <= r_h_imm;
                r_rs1_val   <= w_s1_val;
                r_rs2_val   <= w_s2_val;
                r_rs1_tag   <= w_s1_tag;
                r_rs2_tag   <= w_s2_tag;
            end
        end
    end

    assign issue     = r_issue;
    assign rs_en     = r_rs_en;
    assign lsb_en    = r_lsb_en;
    assign rob_pos   = r_rob_pos;
    assign opcode    = r_opcode;
    assign funct3    = r_funct3;
    assign funct7    = r_funct7;
    assign rd        = r_rd;
    assign pc        = r_pc;
    assign pred_jump = r_pred_jump;
    assign is_ready  = r_is_ready;
    assign imm       = r_imm;
    assign rs1_val   = r_rs1_val;
    assign rs2_val   = r_rs2_val;
    assign rs1_tag   = r_rs1_tag;
    assign rs2_tag   = r_rs2_tag;

endmodule
